// File: rtl/blink_period_meter.sv
// ---------------------------------------------------------------------------
// blink_period_meter
//
// Measures a slow square wave (for example a divided-clock LED drive) against
// CLOCK_50. SIG_IN is synchronised, its edges are detected, and the meter
// reports:
//   - the period between the last two rising edges, in clock cycles
//   - the high time from a rising edge to the following falling edge
//   - whether the last period lies within EXPECTED +/- TOLERANCE
//   - whether the input has stopped toggling for TIMEOUT cycles
//
// Ports
//   CLOCK_50      in   1      sole clock, rising edge
//   RESET_N       in   1      asynchronous assert, active-low reset
//   SIG_IN        in   1      asynchronous signal under measurement
//   PERIOD        out  CNT_W  cycles between the last two rising edges
//   HIGH_TIME     out  CNT_W  cycles from last rising edge to following fall
//   PERIOD_VALID  out  1      one-cycle pulse when PERIOD/IN_TOL update
//   IN_TOL        out  1      last PERIOD within EXPECTED +/- TOLERANCE
//   STALLED       out  1      no rising edge seen for TIMEOUT cycles
//
// Reset release is expected to be synchronous to CLOCK_50 (the board reset
// path provides that); assertion is asynchronous and clears every flop.
// ---------------------------------------------------------------------------
module blink_period_meter #(
    parameter int CNT_W       = 32,
    parameter int EXPECTED    = 50000000,
    parameter int TOLERANCE   = 50000,
    parameter int TIMEOUT     = 100000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic             SIG_IN,
    output logic [CNT_W-1:0] PERIOD,
    output logic [CNT_W-1:0] HIGH_TIME,
    output logic             PERIOD_VALID,
    output logic             IN_TOL,
    output logic             STALLED
);

    localparam logic [CNT_W-1:0] TIMEOUT_M1   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W:0]   EXPECTED_EXT = (CNT_W + 1)'(EXPECTED);
    localparam logic [CNT_W:0]   TOL_EXT      = (CNT_W + 1)'(TOLERANCE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STALL   = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Input synchroniser and edge detector
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;
    logic                   sig_s;
    logic                   rise;
    logic                   fall;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], SIG_IN};
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign sig_s = sync_reg[SYNC_STAGES-1];
    // prev resets low, so an input already high at reset release produces one
    // rise; that rise lands in IDLE and only arms the meter.
    assign rise  = sig_s & ~prev_reg;
    assign fall  = ~sig_s & prev_reg;

    // -----------------------------------------------------------------------
    // Measurement state
    // -----------------------------------------------------------------------
    state_t           state_reg,   state_next;
    logic [CNT_W-1:0] cnt_reg,     cnt_next;
    logic [CNT_W-1:0] period_reg,  period_next;
    logic [CNT_W-1:0] high_reg,    high_next;
    logic             valid_reg,   valid_next;
    logic             in_tol_reg,  in_tol_next;
    logic             stalled_reg, stalled_next;

    logic [CNT_W-1:0] cnt_plus;
    logic [CNT_W:0]   diff;
    logic [CNT_W:0]   diff_mag;
    logic             within_tol;

    // cnt counts completed cycles since the last rise, so the interval that
    // ends on this cycle is cnt+1. cnt never exceeds TIMEOUT-1, so cnt+1 fits.
    assign cnt_plus = cnt_reg + CNT_W'(1);

    // One extra bit makes the difference a two's-complement value that
    // cannot wrap; take its magnitude before comparing with the tolerance.
    assign diff       = {1'b0, cnt_plus} - EXPECTED_EXT;
    assign diff_mag   = diff[CNT_W] ? (~diff + (CNT_W + 1)'(1)) : diff;
    assign within_tol = (diff_mag <= TOL_EXT);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            period_reg  <= '0;
            high_reg    <= '0;
            valid_reg   <= 1'b0;
            in_tol_reg  <= 1'b0;
            stalled_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            period_reg  <= period_next;
            high_reg    <= high_next;
            valid_reg   <= valid_next;
            in_tol_reg  <= in_tol_next;
            stalled_reg <= stalled_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        period_next  = period_reg;
        high_next    = high_reg;
        valid_next   = 1'b0;
        in_tol_next  = in_tol_reg;
        stalled_next = stalled_reg;

        case (state_reg)
            IDLE: begin
                if (rise) begin
                    state_next = MEASURE;
                    cnt_next   = '0;
                end
            end

            MEASURE: begin
                // A rise on the timeout cycle still counts as a valid period.
                if (rise) begin
                    period_next = cnt_plus;
                    valid_next  = 1'b1;
                    in_tol_next = within_tol;
                    cnt_next    = '0;
                end else begin
                    if (fall) begin
                        high_next = cnt_plus;
                    end
                    if (cnt_reg == TIMEOUT_M1) begin
                        state_next   = STALL;
                        stalled_next = 1'b1;
                        in_tol_next  = 1'b0;
                    end else begin
                        cnt_next = cnt_plus;
                    end
                end
            end

            STALL: begin
                // The interval spanning a stall is meaningless, so the rise
                // that ends it restarts the count without a report.
                if (rise) begin
                    state_next   = MEASURE;
                    stalled_next = 1'b0;
                    cnt_next     = '0;
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign PERIOD       = period_reg;
    assign HIGH_TIME    = high_reg;
    assign PERIOD_VALID = valid_reg;
    assign IN_TOL       = in_tol_reg;
    assign STALLED      = stalled_reg;

endmodule

// File: tb/tb_blink_period_meter.sv
// ---------------------------------------------------------------------------
// tb_blink_period_meter
//
// Directed bench for blink_period_meter with CNT_W=16, EXPECTED=100,
// TOLERANCE=2, TIMEOUT=300, SYNC_STAGES=2. SIG_IN changes only on falling
// clock edges, so rises driven N falling edges apart are detected exactly N
// cycles apart. A monitor records every PERIOD_VALID cycle; the scenario
// tasks compare what it recorded with hand-computed values.
// ---------------------------------------------------------------------------
module tb_blink_period_meter;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             period_valid;
    logic             in_tol;
    logic             stalled;

    int errors = 0;
    int checks = 0;

    // Monitor state
    int               pulse_cnt    = 0;
    logic [CNT_W-1:0] last_period  = '0;
    logic [CNT_W-1:0] last_high    = '0;
    logic             last_in_tol  = 1'b0;
    logic             stalled_seen = 1'b0;

    blink_period_meter #(
        .CNT_W      (16),
        .EXPECTED   (100),
        .TOLERANCE  (2),
        .TIMEOUT    (300),
        .SYNC_STAGES(2)
    ) dut (
        .CLOCK_50    (clk),
        .RESET_N     (rst_n),
        .SIG_IN      (sig_in),
        .PERIOD      (period),
        .HIGH_TIME   (high_time),
        .PERIOD_VALID(period_valid),
        .IN_TOL      (in_tol),
        .STALLED     (stalled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (period_valid === 1'b1) begin
            pulse_cnt   = pulse_cnt + 1;
            last_period = period;
            last_high   = high_time;
            last_in_tol = in_tol;
            $display("[%0t] report: period=%0d high=%0d in_tol=%0b",
                     $time, period, high_time, in_tol);
        end
        if (stalled === 1'b1) stalled_seen = 1'b1;
    end

    // One square-wave cycle: rise now, fall after h cycles, end after h+l.
    task automatic wave(input int h, input int l);
        sig_in = 1'b1;
        repeat (h) @(negedge clk);
        sig_in = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (period !== 16'd0 || high_time !== 16'd0 || period_valid !== 1'b0 ||
            in_tol !== 1'b0 || stalled !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got period=%0d high=%0d valid=%0b tol=%0b stalled=%0b, want all 0",
                     period, high_time, period_valid, in_tol, stalled);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_nominal();
        int base;
        base = pulse_cnt;
        wave(50, 50);
        checks++;
        if (pulse_cnt - base !== 0) begin
            errors++;
            $display("FAIL arm_first_rise: got %0d pulses, want 0", pulse_cnt - base);
        end
        repeat (3) wave(50, 50);
        checks++;
        if (pulse_cnt - base !== 3) begin
            errors++;
            $display("FAIL nominal_pulses: got %0d pulses, want 3", pulse_cnt - base);
        end
        checks++;
        if (last_period !== 16'd100 || last_high !== 16'd50 || last_in_tol !== 1'b1) begin
            errors++;
            $display("FAIL nominal_values: got period=%0d high=%0d tol=%0b, want 100 50 1",
                     last_period, last_high, last_in_tol);
        end
        $display("test_nominal done");
    endtask

    task automatic test_tolerance();
        wave(53, 50);   // its rise reports the previous 100-cycle wave
        wave(48, 50);   // its rise reports 103
        checks++;
        if (last_period !== 16'd103 || last_in_tol !== 1'b0 || last_high !== 16'd53) begin
            errors++;
            $display("FAIL period_103: got period=%0d tol=%0b high=%0d, want 103 0 53",
                     last_period, last_in_tol, last_high);
        end
        wave(50, 50);   // its rise reports 98
        checks++;
        if (last_period !== 16'd98 || last_in_tol !== 1'b1 || last_high !== 16'd48) begin
            errors++;
            $display("FAIL period_98: got period=%0d tol=%0b high=%0d, want 98 1 48",
                     last_period, last_in_tol, last_high);
        end
        $display("test_tolerance done");
    endtask

    task automatic test_stall();
        int base;
        base = pulse_cnt;
        // Rise (reports 100), then low forever. Detected rise is on the 3rd
        // clock after the drive; stall registers 300 clocks later.
        sig_in = 1'b1;
        repeat (50) @(negedge clk);
        sig_in = 1'b0;
        repeat (252) @(negedge clk);
        checks++;
        if (stalled !== 1'b0) begin
            errors++;
            $display("FAIL stall_early: got stalled=%0b, want 0", stalled);
        end
        @(negedge clk);
        checks++;
        if (stalled !== 1'b1 || in_tol !== 1'b0) begin
            errors++;
            $display("FAIL stall_set: got stalled=%0b tol=%0b, want 1 0", stalled, in_tol);
        end
        checks++;
        if (pulse_cnt - base !== 1) begin
            errors++;
            $display("FAIL stall_pulses: got %0d pulses, want 1", pulse_cnt - base);
        end
        repeat (40) @(negedge clk);
        checks++;
        if (period !== 16'd100 || high_time !== 16'd50 || stalled !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold: got period=%0d high=%0d stalled=%0b, want 100 50 1",
                     period, high_time, stalled);
        end
        // Restart rise: clears STALLED, no report.
        base = pulse_cnt;
        sig_in = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (stalled !== 1'b0 || pulse_cnt - base !== 0) begin
            errors++;
            $display("FAIL stall_restart: got stalled=%0b pulses=%0d, want 0 0",
                     stalled, pulse_cnt - base);
        end
        repeat (45) @(negedge clk);
        sig_in = 1'b0;
        repeat (50) @(negedge clk);
        sig_in = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (pulse_cnt - base !== 1 || last_period !== 16'd100) begin
            errors++;
            $display("FAIL after_stall: got pulses=%0d period=%0d, want 1 100",
                     pulse_cnt - base, last_period);
        end
        $display("test_stall done");
    endtask

    task automatic test_timeout_edge();
        int base;
        // Continues 5 cycles into a high phase started by test_stall.
        base = pulse_cnt;
        stalled_seen = 1'b0;
        repeat (45) @(negedge clk);
        sig_in = 1'b0;
        repeat (250) @(negedge clk);
        sig_in = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (pulse_cnt - base !== 1 || last_period !== 16'd300 || last_in_tol !== 1'b0) begin
            errors++;
            $display("FAIL period_300: got pulses=%0d period=%0d tol=%0b, want 1 300 0",
                     pulse_cnt - base, last_period, last_in_tol);
        end
        checks++;
        if (stalled_seen !== 1'b0 || stalled !== 1'b0) begin
            errors++;
            $display("FAIL no_stall_300: got stalled_seen=%0b stalled=%0b, want 0 0",
                     stalled_seen, stalled);
        end
        repeat (45) @(negedge clk);
        sig_in = 1'b0;
        repeat (50) @(negedge clk);
        $display("test_timeout_edge done");
    endtask

    task automatic test_reset_mid();
        int base;
        sig_in = 1'b1;   // reports 100, so outputs are non-zero
        repeat (20) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (period !== 16'd0 || high_time !== 16'd0 || period_valid !== 1'b0 ||
            in_tol !== 1'b0 || stalled !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got period=%0d high=%0d valid=%0b tol=%0b stalled=%0b, want all 0",
                     period, high_time, period_valid, in_tol, stalled);
        end
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        base = pulse_cnt;
        wave(50, 50);
        checks++;
        if (pulse_cnt - base !== 0 || period !== 16'd0) begin
            errors++;
            $display("FAIL reset_rearm: got pulses=%0d period=%0d, want 0 0",
                     pulse_cnt - base, period);
        end
        sig_in = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (pulse_cnt - base !== 1 || last_period !== 16'd100 || last_high !== 16'd50) begin
            errors++;
            $display("FAIL reset_second_rise: got pulses=%0d period=%0d high=%0d, want 1 100 50",
                     pulse_cnt - base, last_period, last_high);
        end
        repeat (45) @(negedge clk);
        sig_in = 1'b0;
        repeat (50) @(negedge clk);
        $display("test_reset_mid done");
    endtask

    task automatic test_high_through_reset();
        int base;
        rst_n  = 1'b0;
        sig_in = 1'b1;
        repeat (4) @(negedge clk);
        base = pulse_cnt;
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        sig_in = 1'b0;
        repeat (70) @(negedge clk);
        checks++;
        if (pulse_cnt - base !== 0) begin
            errors++;
            $display("FAIL startup_rise: got %0d pulses, want 0", pulse_cnt - base);
        end
        sig_in = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (pulse_cnt - base !== 1 || last_period !== 16'd100 || last_high !== 16'd30 ||
            last_in_tol !== 1'b1) begin
            errors++;
            $display("FAIL first_genuine_rise: got pulses=%0d period=%0d high=%0d tol=%0b, want 1 100 30 1",
                     pulse_cnt - base, last_period, last_high, last_in_tol);
        end
        $display("test_high_through_reset done");
    endtask

    initial begin
        rst_n  = 1'b0;
        sig_in = 1'b0;
        @(negedge clk);
        test_reset();
        test_nominal();
        test_tolerance();
        test_stall();
        test_timeout_edge();
        test_reset_mid();
        test_high_through_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Backstop: the scenario only uses bounded waits, but never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
